layer_argmax: RTL and testbench

Downstream stage of the output layer. It accepts the stream of activated neuron outputs, one per beat, for a frame of `NUM_NEURONS` values. It tracks the running signed maximum and its index, then presents the winning class index with a valid/ready handshake. It sits between the output-layer neurons (through their output serialiser) and the classification result register.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/argmax_cmp.sv | 25 ++
 rtl/layer_argmax.sv | 137 +++++++++++++
 tb/tb_layer_argmax.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the output-layer classification stages:
// argmax FSM state, default frame geometry and an index-width helper.
package nn_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } argmax_state_t;

  localparam int NN_DATA_WIDTH  = 16;
  localparam int NN_NUM_NEURONS = 10;

  // Bits needed to hold indices 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed strict-greater compare with index select for the
// running argmax. A tie keeps the current best, so the lower index wins.
module argmax_cmp #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  first,
  input  logic [DATA_WIDTH-1:0] cand_data,
  input  logic [IDX_WIDTH-1:0]  cand_idx,
  input  logic [DATA_WIDTH-1:0] best_data,
  input  logic [IDX_WIDTH-1:0]  best_idx,
  output logic [DATA_WIDTH-1:0] win_data,
  output logic [IDX_WIDTH-1:0]  win_idx
);

  always_comb begin
    win_data = best_data;
    win_idx  = best_idx;
    if (first || ($signed(cand_data) > $signed(best_data))) begin
      win_data = cand_data;
      win_idx  = cand_idx;
    end
  end

endmodule

// File: rtl/layer_argmax.sv
// Streaming argmax over one frame of signed neuron outputs, result handed on
// with valid/ready. Define LAYER_ARGMAX_SCORE_EN to expose the winning value.
module layer_argmax
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = NN_NUM_NEURONS,
  parameter int DATA_WIDTH  = NN_DATA_WIDTH,
  parameter int IDX_WIDTH   = idx_width(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_index,
`ifdef LAYER_ARGMAX_SCORE_EN
  output logic [DATA_WIDTH-1:0] out_max,
`endif
  output logic                  out_len_err,
  output argmax_state_t         dbg_state
);

  // Handshake rule: a beat moves when in_valid && in_ready, a result moves
  // when out_valid && out_ready; both ready/valid outputs come from flops.
  localparam int CNT_W = IDX_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NEURONS - 1);

  argmax_state_t         state_q, state_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [IDX_WIDTH-1:0]  out_index_q, out_index_d;
  logic                  len_err_q, len_err_d;
  logic [DATA_WIDTH-1:0] out_max_q, out_max_d;

  logic                  accept;
  logic                  at_last_cnt;
  logic [DATA_WIDTH-1:0] win_data;
  logic [IDX_WIDTH-1:0]  win_idx;

  assign accept      = in_valid && in_ready_q;
  assign at_last_cnt = (beat_cnt_q == LAST_CNT);

  argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_cmp (
    .first     (beat_cnt_q == '0),
    .cand_data (in_data),
    .cand_idx  (beat_cnt_q[IDX_WIDTH-1:0]),
    .best_data (max_q),
    .best_idx  (idx_q),
    .win_data  (win_data),
    .win_idx   (win_idx)
  );

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    max_d       = max_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    len_err_d   = len_err_q;
    out_max_d   = out_max_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          max_d      = win_data;
          idx_d      = win_idx;
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Frame ends on in_last or on the full count, whichever is first.
          if (in_last || at_last_cnt) begin
            state_d     = RESULT;
            beat_cnt_d  = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_index_d = win_idx;
            out_max_d   = win_data;
            len_err_d   = (in_last != at_last_cnt);
          end
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d     = COLLECT;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      beat_cnt_q  <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      len_err_q   <= 1'b0;
      out_max_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      len_err_q   <= len_err_d;
      out_max_q   <= out_max_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign out_len_err = len_err_q;
  assign dbg_state   = state_q;
`ifdef LAYER_ARGMAX_SCORE_EN
  assign out_max     = out_max_q;
`else
  logic unused_max;
  assign unused_max = ^out_max_q;
`endif

endmodule

// File: tb/tb_layer_argmax.sv
// Directed bench for layer_argmax with hand-computed expected results.
// Build with +define+LAYER_ARGMAX_SCORE_EN to also check out_max.
module tb_layer_argmax;
  import nn_pkg::*;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
`ifdef LAYER_ARGMAX_SCORE_EN
  logic [DW-1:0] out_max;
`endif
  logic          out_len_err;
  argmax_state_t dbg_state;

  int n_checks;
  int n_pass;

  layer_argmax #(
    .NUM_NEURONS (N),
    .DATA_WIDTH  (DW),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
`ifdef LAYER_ARGMAX_SCORE_EN
    .out_max     (out_max),
`endif
    .out_len_err (out_len_err),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one beat and hold it until it is accepted.
  task automatic drive_beat(input logic [DW-1:0] d, input logic l);
    int waited;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) check("beat_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] d[N], input int n, input int last_pos);
    for (int i = 0; i < n; i++) drive_beat(d[i], (i == last_pos));
  endtask

  // Called right after the frame-end beat edge: result must already be valid.
  task automatic expect_result(input string tag, input logic [IW-1:0] idx,
                               input logic [DW-1:0] mx, input logic err,
                               input logic drop_valid);
    int waited;
    check({tag, "_valid_lat"}, {31'd0, out_valid}, 32'd1);
    waited = 0;
    while (!out_valid && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_index"}, {28'd0, out_index}, {28'd0, idx});
`ifdef LAYER_ARGMAX_SCORE_EN
    check({tag, "_max"}, {16'd0, out_max}, {16'd0, mx});
`else
    if (mx === 'x) check({tag, "_max_arg"}, 32'd0, 32'd1);
`endif
    check({tag, "_len_err"}, {31'd0, out_len_err}, {31'd0, err});
    check({tag, "_in_ready_lo"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (drop_valid) in_valid = 1'b0;
    check({tag, "_valid_fall"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_hi"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_index_kept"}, {28'd0, out_index}, {28'd0, idx});
  endtask

  logic [DW-1:0] f_norm [N] = '{16'd3, 16'd7, 16'd2, 16'h7FFF, 16'd5, 16'd1, 16'd0, 16'd0, 16'd4, 16'd9};
  logic [DW-1:0] f_tie  [N] = '{16'd5, 16'd9, 16'd9, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [DW-1:0] f_neg  [N] = '{16'hFFF0, 16'hFFFE, 16'h8000, 16'hFFF1, 16'hFFF2,
                                16'hFFF3, 16'hFFF4, 16'hFFF5, 16'hFFF6, 16'hFFF7};
  logic [DW-1:0] f_short[N] = '{16'd1, 16'd2, 16'd8, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [DW-1:0] f_nolst[N] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
  logic [DW-1:0] f_one  [N] = '{16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [DW-1:0] f_bp   [N] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd100, 16'd4, 16'd3, 16'd2, 16'd1};
  logic [DW-1:0] f_bp2  [N] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB,
                                16'hFFFA, 16'hFFF9, 16'h0000, 16'hFFF8, 16'hFFF7};
  logic [DW-1:0] f_part [N] = '{16'd1, 16'd2, 16'h7000, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0, 16'd0};
  logic [DW-1:0] f_post [N] = '{16'd1, 16'd50, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_index", {28'd0, out_index}, 32'd0);
    check("rst_len_err",   {31'd0, out_len_err}, 32'd0);
    check("rst_state",     {31'd0, dbg_state}, {31'd0, COLLECT});
`ifdef LAYER_ARGMAX_SCORE_EN
    check("rst_out_max",   {16'd0, out_max}, 32'd0);
`endif

    send_frame(f_norm, 10, 9);
    check("norm_state", {31'd0, dbg_state}, {31'd0, RESULT});
    expect_result("norm", 4'd3, 16'h7FFF, 1'b0, 1'b1);

    send_frame(f_tie, 10, 9);
    expect_result("tie", 4'd1, 16'd9, 1'b0, 1'b1);

    send_frame(f_neg, 10, 9);
    expect_result("neg", 4'd1, 16'hFFFE, 1'b0, 1'b1);

    send_frame(f_short, 5, 4);
    expect_result("short", 4'd2, 16'd8, 1'b1, 1'b1);

    send_frame(f_nolst, 10, -1);
    expect_result("nolast", 4'd9, 16'd2, 1'b1, 1'b1);

    send_frame(f_one, 1, 0);
    expect_result("single", 4'd0, 16'hFFFF, 1'b1, 1'b1);

    // Backpressure: in_valid stays high with stale data while result waits.
    send_frame(f_bp, 10, 9);
    in_data = 16'h7FFF;
    in_last = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_index",    {28'd0, out_index}, 32'd5);
    end
    expect_result("bp", 4'd5, 16'd100, 1'b0, 1'b1);
    send_frame(f_bp2, 10, 9);
    expect_result("bp_next", 4'd7, 16'h0000, 1'b0, 1'b1);

    // Reset mid-frame after beat 6.
    send_frame(f_part, 7, -1);
    rst = 1'b0;
    #1;
    check("mrst_out_index", {28'd0, out_index}, 32'd0);
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_len_err",   {31'd0, out_len_err}, 32'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    send_frame(f_post, 10, 9);
    expect_result("post_rst", 4'd1, 16'd50, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
